// File: rtl/stream_mux.sv
// Registered N-channel stream multiplexer with a fixed-select mode and a round-robin
// mode. One output register stage sits behind a valid/ready handshake on every channel.
module stream_mux #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS-1:0]       a_valid,
    output logic [CHANNELS-1:0]       a_ready,
    input  logic [SEL_W-1:0]          s,
    input  logic                      rr,
    output logic [WIDTH-1:0]          z,
    output logic                      z_valid,
    input  logic                      z_ready,
    output logic [SEL_W-1:0]          z_chan,
    output logic [31:0]               count
);

    logic [WIDTH-1:0] z_q, z_d;
    logic             z_valid_q, z_valid_d;
    logic [SEL_W-1:0] z_chan_q, z_chan_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [31:0]      count_q, count_d;

    logic             le;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] sel_data;

    assign le = !z_valid_q || z_ready;

    // Round-robin scans offsets from the far end down so the channel nearest
    // to last+1 is the one left standing in grant.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant       = '0;
        if (!rr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (s == SEL_W'(i) && a_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(i);
                end
            end
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                idx = (int'(last_q) + k) % CHANNELS;
                if (a_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_data = a[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        a_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            a_ready[i] = !rst && le && grant_valid && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        z_d       = z_q;
        z_valid_d = z_valid_q;
        z_chan_d  = z_chan_q;
        last_d    = last_q;
        count_d   = count_q;
        if (z_valid_q && z_ready) begin
            count_d = count_q + 32'd1;
        end
        if (le) begin
            z_valid_d = grant_valid;
            if (grant_valid) begin
                z_d      = sel_data;
                z_chan_d = grant;
                if (rr) begin
                    last_d = grant;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q       <= '0;
            z_valid_q <= 1'b0;
            z_chan_q  <= '0;
            last_q    <= SEL_W'(CHANNELS - 1);
            count_q   <= '0;
        end else begin
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
            z_chan_q  <= z_chan_d;
            last_q    <= last_d;
            count_q   <= count_d;
        end
    end

    assign z       = z_q;
    assign z_valid = z_valid_q;
    assign z_chan  = z_chan_q;
    assign count   = count_q;

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Registered N-channel successor to the 2:1 combinational `mux`.
- Selects one of CHANNELS input streams onto a single output stream using valid/ready handshakes.
- Two selection modes: fixed (explicit select `s`, legacy behaviour) and round-robin arbitration.
- Sits between producer channels and a shared consumer; `$show_result`-style benches observe `z`, `z_chan` and `count`.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels (>=2).
- SEL_W is a localparam, not overridable: SEL_W = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- a  in  CHANNELS*WIDTH  flattened input data; channel i at a[i*WIDTH +: WIDTH].
- a_valid  in  CHANNELS  per-channel data valid.
- a_ready  out  CHANNELS  per-channel accept; at most one bit set.
- s  in  SEL_W  channel select, used when rr=0.
- rr  in  1  mode: 0 = fixed select, 1 = round-robin.
- z  out  WIDTH  registered output data.
- z_valid  out  1  output valid.
- z_ready  in  1  consumer accept.
- z_chan  out  SEL_W  source channel of current z.
- count  out  32  completed output transfers.

Behaviour:
- Reset (rst=1 at clock edge) sets: z=0, z_valid=0, z_chan=0, count=0, rr pointer last=CHANNELS-1 (so channel 0 has first priority).
  - While rst=1, a_ready=0.
  - Reset mid-transfer drops any held word.
- Load enable: le = !z_valid || z_ready (single-stage pipeline; full throughput at z_ready=1).
- Grant selection, combinational:
  - rr=0: g=s; grant valid iff s<CHANNELS and a_valid[s].
    - s>=CHANNELS (non-power-of-2 CHANNELS): no grant.
  - rr=1: g = first i with a_valid[i], searching circularly from last+1. Grant valid iff any a_valid bit is set.
- a_ready[i] = !rst && le && grant_valid && (g==i).
  - a_ready may depend on a_valid.
  - Producers must not make a_valid depend on a_ready.
  - Input transfer occurs when a_valid[i] && a_ready[i].
- On an edge with le=1:
  - z <= a[g], z_chan <= g, z_valid <= grant_valid.
  - When no grant: z and z_chan hold, z_valid <= 0.
- On an edge with le=0: z, z_chan, z_valid hold. Data is stable under backpressure.
- Latency: data accepted at edge k appears on z after edge k (one cycle).
- last <= g only on an input transfer with rr=1. Fixed-mode transfers leave last unchanged.
- count increments on z_valid && z_ready. It wraps from 2^32-1 to 0.
- Mode or s changes take effect on the next arbitration; a held output word is unaffected.
- Simultaneous output drain and new input accept in the same cycle is required (le=1 via z_ready).
- A single active channel in rr mode is granted every cycle; no bubbles.

Test Plan:
1. Reset: rst=1 for 2 cycles with all a_valid=1 -> a_ready=0000, z=0, z_valid=0, z_chan=0, count=0.
2. Legacy fixed mode: rr=0, s=1, ch0=777, ch1=999, a_valid=0011, z_ready=1 -> a_ready=0010; after 1 edge z=999, z_chan=1, z_valid=1; count=1 after the next edge.
3. Round-robin fairness: rr=1, ch0..3 = 10,11,12,13, all valid, z_ready=1 -> z sequence 10,11,12,13,10 with z_chan 0,1,2,3,0; count=5 after 5 output transfers; no idle cycles.
4. Backpressure: z_valid=1, z=11, z_ready=0 for 3 cycles -> z=11 and z_chan=1 held, a_ready=0000, count unchanged; z_ready=1 -> z=12 on the next edge.
5. Round-robin skip plus fixed/out-of-range select:
   - rr=1 with a_valid=0101 after last=2 -> grants 0 then 2 then 0.
   - With CHANNELS=3, rr=0, s=3 -> a_ready=000, z_valid falls to 0 after the pending word drains.
6. Reset mid-stream: rst=1 while z_valid=1 and z_ready=0 -> next edge z_valid=0, z=0, count=0; after release, round-robin restarts at channel 0.
